// File: rtl/sample_delay_line.sv
// -----------------------------------------------------------------------------
// sample_delay_line
//
// FIR sample delay line with a valid/ready sample input and a per-frame
// handshake toward a MAC controller. Each accepted sample shifts into slot 0,
// and older samples move one slot deeper. A single-cycle frame_start then
// tells the MAC that shift_bus holds a new frame. The line stays frozen
// until the MAC answers with mac_done, and only then is the next sample
// accepted.
//
// Parameters
//   DATA_WIDTH  width of one signed two's-complement sample
//   K           number of taps / delay-line depth (K >= 2)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_sample    new sample x[n]
//   in_valid     in_sample is valid
//   in_ready     block can accept a sample this cycle (IDLE)
//   shift_bus    slot i at [i*DATA_WIDTH +: DATA_WIDTH] holds x[n-i]
//   frame_start  one-cycle pulse: shift_bus holds a new frame
//   mac_done     MAC has finished all K taps of the current frame
//   busy         a frame is in progress (BUSY)
//   fill_count   accepted samples since reset, saturating at K  (optional)
//   primed       delay line holds K real samples                 (optional)
//
// Configuration
//   SAMPLE_DELAY_LINE_FILL_TRACK_EN  define to add fill_count / primed.
// -----------------------------------------------------------------------------
module sample_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [DATA_WIDTH-1:0]   in_sample,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [K*DATA_WIDTH-1:0] shift_bus,
    output logic                           frame_start,
    input  logic                           mac_done,
    output logic                           busy
`ifdef SAMPLE_DELAY_LINE_FILL_TRACK_EN
   ,output logic [$clog2(K+1)-1:0]         fill_count
   ,output logic                           primed
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   frame_start_q, frame_start_d;
    logic [DATA_WIDTH-1:0]  shift_q [K];
    logic [DATA_WIDTH-1:0]  shift_d [K];
    logic                   accept;

    // A sample is taken only when the source offers it and the line is idle.
    assign accept = in_valid && (state_q == IDLE);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d       = state_q;
        frame_start_d = 1'b0;
        shift_d       = shift_q;

        unique case (state_q)
            IDLE: begin
                // mac_done is meaningless here and is ignored.
                if (accept) begin
                    shift_d[0] = in_sample;
                    for (int i = 1; i < K; i++) begin
                        shift_d[i] = shift_q[i-1];
                    end
                    frame_start_d = 1'b1;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                // The line is frozen and in_valid is ignored; mac_done is
                // honoured even in the frame_start cycle.
                if (mac_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_start_q <= 1'b0;
            // NOTE: the delay-line storage is reset on purpose. The MAC
            // must see zeros for taps that have not been filled yet, so
            // this array stays in flops and cannot be mapped to a RAM.
            for (int i = 0; i < K; i++) begin
                shift_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            frame_start_q <= frame_start_d;
            shift_q       <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional fill tracking
    // ------------------------------------------------------------------
`ifdef SAMPLE_DELAY_LINE_FILL_TRACK_EN
    localparam int CW = $clog2(K+1);
    localparam logic [CW-1:0] FILL_MAX = CW'(K);
    localparam logic [CW-1:0] FILL_ONE = CW'(1);

    logic [CW-1:0] fill_count_q, fill_count_d;
    logic          primed_q, primed_d;

    always_comb begin
        fill_count_d = fill_count_q;
        if (accept && (fill_count_q != FILL_MAX)) begin
            fill_count_d = fill_count_q + FILL_ONE;
        end
        // Computed from the next count so primed rises on the same edge
        // that the count reaches K.
        primed_d = (fill_count_d == FILL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count_q <= '0;
            primed_q     <= 1'b0;
        end else begin
            fill_count_q <= fill_count_d;
            primed_q     <= primed_d;
        end
    end

    assign fill_count = fill_count_q;
    assign primed     = primed_q;
`endif

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // ------------------------------------------------------------------
    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == BUSY);
    assign frame_start = frame_start_q;

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign shift_bus[g*DATA_WIDTH +: DATA_WIDTH] = shift_q[g];
    end

endmodule

// File: tb/tb_sample_delay_line.sv
// -----------------------------------------------------------------------------
// tb_sample_delay_line
//
// Directed, self-checking bench for sample_delay_line (DATA_WIDTH=16, K=8).
// Inputs are driven 1 time unit after the rising edge, and outputs are
// checked at that same point.
// -----------------------------------------------------------------------------
module tb_sample_delay_line;

    localparam int DW = 16;
    localparam int K  = 8;
    localparam int BW = K*DW;

    logic                  clk;
    logic                  rst_n;
    logic signed [DW-1:0]  in_sample;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [BW-1:0]  shift_bus;
    logic                  frame_start;
    logic                  mac_done;
    logic                  busy;
`ifdef SAMPLE_DELAY_LINE_FILL_TRACK_EN
    logic [$clog2(K+1)-1:0] fill_count;
    logic                   primed;
`endif

    int checks = 0;
    int errors = 0;

    // Expected delay-line contents and fill level.
    logic [DW-1:0] exp_slots [K];
    int            exp_fill;
    logic [BW-1:0] snap;

    sample_delay_line #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .shift_bus   (shift_bus),
        .frame_start (frame_start),
        .mac_done    (mac_done),
        .busy        (busy)
`ifdef SAMPLE_DELAY_LINE_FILL_TRACK_EN
       ,.fill_count  (fill_count)
       ,.primed      (primed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] exp_bus();
        logic [BW-1:0] b;
        for (int i = 0; i < K; i++) b[i*DW +: DW] = exp_slots[i];
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < K; i++) exp_slots[i] = '0;
        exp_fill = 0;
    endtask

    task automatic model_push(input logic [DW-1:0] v);
        for (int i = K-1; i > 0; i--) exp_slots[i] = exp_slots[i-1];
        exp_slots[0] = v;
        if (exp_fill < K) exp_fill++;
    endtask

    task automatic check_fill();
`ifdef SAMPLE_DELAY_LINE_FILL_TRACK_EN
        check("fill_count", BW'(fill_count), BW'(exp_fill));
        check("primed", BW'(primed), BW'(exp_fill == K));
`endif
    endtask

    // Offer v while IDLE, take the accept edge, and check the new frame.
    task automatic do_accept(input logic [DW-1:0] v);
        in_valid  = 1'b1;
        in_sample = v;
        mac_done  = 1'b0;
        step();
        model_push(v);
        check("accept_frame_start", BW'(frame_start), BW'(1'b1));
        check("accept_busy", BW'(busy), BW'(1'b1));
        check("accept_in_ready", BW'(in_ready), BW'(1'b0));
        check("accept_bus", shift_bus, exp_bus());
        check_fill();
    endtask

    // Return mac_done for one edge and check the line is idle again.
    task automatic do_done();
        in_valid = 1'b0;
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        check("done_in_ready", BW'(in_ready), BW'(1'b1));
        check("done_frame_start", BW'(frame_start), BW'(1'b0));
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        mac_done  = 1'b0;
        model_clear();

        // ---- Asynchronous reset, checked before any clock edge ----
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", BW'(in_ready), BW'(1'b1));
        check("rst_busy", BW'(busy), BW'(1'b0));
        check("rst_frame_start", BW'(frame_start), BW'(1'b0));
        check("rst_bus", shift_bus, '0);
        check_fill();
        #20 rst_n = 1'b1;  // t=22, between edges

        // ---- Fill with 10..80; the first edge after reset accepts ----
        for (int v = 1; v <= 8; v++) begin
            do_accept(DW'(v*10));
            do_done();
        end
        check("fill_final_bus", shift_bus,
              {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80});

        // One more accept: fill_count saturates at 8.
        do_accept(16'd90);
        do_done();

        // ---- Line frozen in BUSY while a sample waits ----
        do_accept(16'd5);
        snap      = exp_bus();
        in_valid  = 1'b1;
        in_sample = 16'd99;
        for (int c = 0; c < 3; c++) begin
            step();
            check("busy_hold_bus", shift_bus, snap);
            check("busy_hold_busy", BW'(busy), BW'(1'b1));
            check("busy_hold_fs", BW'(frame_start), BW'(1'b0));
        end
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        check("busy_release_ready", BW'(in_ready), BW'(1'b1));
        check("busy_release_bus", shift_bus, snap);
        // 99 is still offered and is taken on the first idle edge.
        step();
        model_push(16'd99);
        check("held_accept_fs", BW'(frame_start), BW'(1'b1));
        check("held_slot0", BW'(shift_bus[0 +: DW]), BW'(16'd99));
        check("held_slot1", BW'(shift_bus[DW +: DW]), BW'(16'd5));
        check("held_bus", shift_bus, exp_bus());
        do_done();

        // ---- Back-to-back: mac_done held high, frame_start every 2 cycles ----
        in_valid = 1'b1;
        mac_done = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_sample = DW'(200 + c);
            step();
            if ((c % 2) == 0) begin
                model_push(DW'(200 + c));
                check("b2b_fs_high", BW'(frame_start), BW'(1'b1));
                check("b2b_busy", BW'(busy), BW'(1'b1));
            end else begin
                check("b2b_fs_low", BW'(frame_start), BW'(1'b0));
                check("b2b_ready", BW'(in_ready), BW'(1'b1));
            end
        end
        check("b2b_bus", shift_bus, exp_bus());
        check_fill();
        in_valid = 1'b0;
        mac_done = 1'b0;

        // ---- Sign preservation ----
        do_accept(16'hFFFF);
        check("neg_slot0", BW'(shift_bus[0 +: DW]), BW'(16'hFFFF));
        do_done();
        do_accept(16'h0001);
        check("neg_slot1", BW'(shift_bus[DW +: DW]), BW'(16'hFFFF));
        do_done();

        // ---- mac_done while IDLE is ignored ----
        snap     = exp_bus();
        mac_done = 1'b1;
        step();
        step();
        mac_done = 1'b0;
        check("idle_done_ready", BW'(in_ready), BW'(1'b1));
        check("idle_done_busy", BW'(busy), BW'(1'b0));
        check("idle_done_bus", shift_bus, snap);

        // ---- Reset dropped mid-BUSY, between edges ----
        do_accept(16'h1234);
        in_valid = 1'b0;
        step();  // second BUSY cycle
        check("pre_rst_busy", BW'(busy), BW'(1'b1));
        #3 rst_n = 1'b0;
        #1;       // still before the next rising edge
        model_clear();
        check("mid_rst_ready", BW'(in_ready), BW'(1'b1));
        check("mid_rst_busy", BW'(busy), BW'(1'b0));
        check("mid_rst_fs", BW'(frame_start), BW'(1'b0));
        check("mid_rst_bus", shift_bus, '0);
        check_fill();
        #10 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_fs", BW'(frame_start), BW'(1'b0));
            check("post_rst_ready", BW'(in_ready), BW'(1'b1));
        end
        do_accept(16'h00AB);
        do_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_delay_line.md
SAMPLE_DELAY_LINE -- requirements
Module: sample_delay_line

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one signed two's-complement sample.
REQ-002 SHALL have parameter K, default 8: number of FIR taps (delay-line depth), K >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_sample  input  DATA_WIDTH (signed)  new sample x[n].
REQ-006 SHALL have port in_valid  input  1  in_sample is valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port shift_bus  output  K*DATA_WIDTH (signed)  slot i at bits [i*DATA_WIDTH +: DATA_WIDTH], holding x[n-i].
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse: new shift_bus contents ready for the MAC pass.
REQ-010 SHALL have port mac_done  input  1  MAC controller has finished all K taps of the current frame.
REQ-011 SHALL have port busy  output  1  a frame is in progress (awaiting mac_done).
REQ-012 SHALL have port fill_count  output  $clog2(K+1)  samples accepted since reset, saturating at K (present only with SAMPLE_DELAY_LINE_FILL_TRACK_EN).
REQ-013 SHALL have port primed  output  1  delay line holds K real samples (present only with SAMPLE_DELAY_LINE_FILL_TRACK_EN).

Function
REQ-014 SHALL implement a two-state FSM: IDLE (in_ready=1, busy=0) and BUSY (in_ready=0, busy=1); in_ready and busy are registered-state decodes.
REQ-015 SHALL accept a sample only on a cycle where in_valid=1 and in_ready=1 (handshake).
REQ-016 On acceptance, SHALL at that edge load slot 0 with in_sample, move slot i-1 into slot i for i=1..K-1, discard the old slot K-1, and go IDLE->BUSY.
REQ-017 SHALL assert frame_start for exactly the first BUSY cycle after acceptance, coincident with the updated shift_bus (latency 1 cycle from the accept edge).
REQ-018 SHALL keep shift_bus stable for the whole BUSY state, regardless of in_valid or in_sample.
REQ-019 In BUSY, mac_done=1 at an edge SHALL return the FSM to IDLE; in_ready is 1 in the following cycle.
REQ-020 mac_done in the frame_start cycle SHALL be honoured (minimum frame is 1 BUSY cycle).
REQ-021 mac_done while IDLE SHALL be ignored, with no state change.
REQ-022 in_valid while BUSY SHALL be ignored: no shift, the sample is not consumed, and the source must hold it.
REQ-023 SHALL perform no arithmetic; sample bit patterns pass unmodified (sign preserved).
REQ-024 Back-to-back throughput SHALL be one sample per two cycles when mac_done is returned in the frame_start cycle.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, in_ready=1, busy=0, frame_start=0, all shift_bus slots=0, fill_count=0, primed=0.
REQ-026 Reset asserted during BUSY SHALL abandon the frame; no frame_start is issued after deassertion until a new sample is accepted.
REQ-027 The first clock edge after rst_n rises SHALL be able to accept a sample.

Configuration
REQ-028 Macro SAMPLE_DELAY_LINE_FILL_TRACK_EN: when defined, fill_count increments on each accept, saturating at K, and primed = (fill_count == K), registered. When undefined, the fill_count and primed ports and logic are absent; all other behaviour is identical.

Verification
REQ-029 After reset, shift_bus==0 and in_ready==1; with K=8, accept 10,20,...,80, returning mac_done each frame -> final slots 0..7 = 80,70,...,10.
REQ-030 Accept 5; hold in_valid=1 with in_sample=99 for 4 BUSY cycles, then mac_done -> shift_bus is unchanged during BUSY, and 99 is accepted on the first IDLE cycle.
REQ-031 Accept, then mac_done in the frame_start cycle, with in_valid held high -> frame_start pulses every 2 cycles and is never 2 cycles wide.
REQ-032 Accept -16'sd1 (0xFFFF) -> slot 0 = 0xFFFF and the next sample shifts it to slot 1 unchanged.
REQ-033 Drop rst_n mid-BUSY, between clock edges -> outputs reach their reset values before the next edge, and no frame_start follows deassertion.
REQ-034 With SAMPLE_DELAY_LINE_FILL_TRACK_EN and K=8, accept 9 samples -> fill_count goes 1..8 then holds at 8, and primed rises after the 8th accept.
